// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and helpers for the AXI channel arbiters
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    BURST  = 2'd2
  } arb_state_e;

  // Modulo increment with an explicit wrap so non-power-of-2 counts stay in range
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_rr_prio_sel.sv
// rtl/axi_rr_prio_sel.sv - rotating-priority first-one finder starting at rr_ptr
module axi_rr_prio_sel #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;
  logic [ID_W:0]    sum;
  logic [ID_W:0]    wrapped;

  // Rotate so bit 0 is the requester at rr_ptr; the offset of the first one is the distance
  assign rot = N_REQ'({req, req} >> rr_ptr);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign sum     = {1'b0, rr_ptr} + {1'b0, off};
  assign wrapped = (sum >= N_W) ? (sum - N_W) : sum;
  assign winner  = ID_W'(wrapped);

endmodule

// File: rtl/axi_rr_arbiter_lock.sv
// rtl/axi_rr_arbiter_lock.sv - N-to-1 round-robin AXI channel arbiter with stall and burst lock
module axi_rr_arbiter_lock
  import axi_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int LOCK_LAST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_last_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    out_valid_o,
  output logic                    out_last_o,
  output logic [DATA_W-1:0]       out_data_o,
  input  logic                    out_ready_i,
  output logic [ID_W-1:0]         grant_id_o,
  output logic [N_REQ-1:0]        grant_onehot_o,
  output logic                    busy_o
);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [ID_W-1:0]   lock_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic [N_REQ-1:0]  valid_gated;
  logic [N_REQ-1:0]  win_onehot;
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              cur_valid;
  logic              cur_last;
  logic              last_eff;
  logic              hs;
  logic              done;
  logic              granted;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
  end

  // Masking valids while rst_n is low forces every output to its reset value without waiting for a clock
  assign valid_gated = {N_REQ{rst_n}} & req_valid_i;

  axi_rr_prio_sel #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_prio_sel (
    .req    (valid_gated),
    .rr_ptr (rr_ptr),
    .winner (sel_id),
    .found  (found)
  );

  assign winner     = (state == IDLE) ? sel_id : lock_id;
  assign cur_valid  = valid_gated[winner];
  assign cur_last   = rst_n & req_last_i[winner];
  assign last_eff   = (LOCK_LAST == 0) || cur_last;
  assign hs         = cur_valid & out_ready_i;
  assign done       = hs & last_eff;
  assign win_onehot = N_REQ'(1) << winner;
  assign granted    = (state != IDLE) || found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && found) begin
        lock_id <= sel_id;
      end
      if (done) begin
        rr_ptr <= ID_W'(rr_next(int'(winner), N_REQ));
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (found) begin
          if (!hs)           state_next = LOCKED;
          else if (!last_eff) state_next = BURST;
        end
      end
      LOCKED: begin
        if (hs) state_next = last_eff ? IDLE : BURST;
      end
      BURST: begin
        if (hs && cur_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A locked requester keeps its grant even if it illegally drops valid
  always_comb begin
    out_valid_o    = cur_valid;
    out_last_o     = cur_last;
    out_data_o     = data_arr[winner];
    grant_id_o     = winner;
    grant_onehot_o = granted ? win_onehot : '0;
    req_ready_o    = (out_ready_i && cur_valid) ? win_onehot : '0;
    busy_o         = (state != IDLE);
  end

endmodule

// File: tb/tb_axi_rr_arbiter_lock.sv
// tb/tb_axi_rr_arbiter_lock.sv - directed self-checking bench for axi_rr_arbiter_lock
module tb_axi_rr_arbiter_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // N=4, release after every beat
  logic         rst_n_a;
  logic [3:0]   valid_a, last_a, rdy_a, goh_a;
  logic [127:0] data_a;
  logic         ready_a, ov_a, ol_a, busy_a;
  logic [31:0]  od_a;
  logic [1:0]   gid_a;

  // N=4, hold grant until last
  logic         rst_n_b;
  logic [3:0]   valid_b, last_b, rdy_b, goh_b;
  logic [127:0] data_b;
  logic         ready_b, ov_b, ol_b, busy_b;
  logic [31:0]  od_b;
  logic [1:0]   gid_b;

  // N=3, non-power-of-2
  logic         rst_n_c;
  logic [2:0]   valid_c, last_c, rdy_c, goh_c;
  logic [95:0]  data_c;
  logic         ready_c, ov_c, ol_c, busy_c;
  logic [31:0]  od_c;
  logic [1:0]   gid_c;

  axi_rr_arbiter_lock #(.N_REQ(4), .DATA_W(32), .LOCK_LAST(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid_i(valid_a), .req_last_i(last_a),
    .req_data_i(data_a), .req_ready_o(rdy_a), .out_valid_o(ov_a), .out_last_o(ol_a),
    .out_data_o(od_a), .out_ready_i(ready_a), .grant_id_o(gid_a),
    .grant_onehot_o(goh_a), .busy_o(busy_a)
  );

  axi_rr_arbiter_lock #(.N_REQ(4), .DATA_W(32), .LOCK_LAST(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid_i(valid_b), .req_last_i(last_b),
    .req_data_i(data_b), .req_ready_o(rdy_b), .out_valid_o(ov_b), .out_last_o(ol_b),
    .out_data_o(od_b), .out_ready_i(ready_b), .grant_id_o(gid_b),
    .grant_onehot_o(goh_b), .busy_o(busy_b)
  );

  axi_rr_arbiter_lock #(.N_REQ(3), .DATA_W(32), .LOCK_LAST(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n_c), .req_valid_i(valid_c), .req_last_i(last_c),
    .req_data_i(data_c), .req_ready_o(rdy_c), .out_valid_o(ov_c), .out_last_o(ol_c),
    .out_data_o(od_c), .out_ready_i(ready_c), .grant_id_o(gid_c),
    .grant_onehot_o(goh_c), .busy_o(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int beat;

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    valid_a = '0; last_a = '0; ready_a = 1'b0;
    valid_b = '0; last_b = '0; ready_b = 1'b0;
    valid_c = '0; last_c = '0; ready_c = 1'b0;
    data_a = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    data_b = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hB000_0000};
    data_c = {32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
    #1;
    check("rst_out_valid", 32'(ov_a), 32'd0);
    check("rst_req_ready", 32'(rdy_a), 32'd0);
    check("rst_onehot", 32'(goh_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_grant_id", 32'(gid_a), 32'd0);
    step();
    step();
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;

    // all valid, always ready: strict rotation
    valid_a = 4'hF; ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_grant_id", 32'(gid_a), 32'(i % 4));
      check("rr_req_ready", 32'(rdy_a), 32'(4'b0001 << (i % 4)));
      step();
    end

    // stalled single requester holds grant while another arrives
    valid_a = 4'b0100; ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_grant", 32'(gid_a), 32'd2);
      check("stall_data", od_a, 32'h2222_2222);
      check("stall_busy", 32'(busy_a), (i > 0) ? 32'd1 : 32'd0);
      step();
    end
    valid_a = 4'b0110;
    #1;
    check("stall_hold_grant", 32'(gid_a), 32'd2);
    check("stall_hold_data", od_a, 32'h2222_2222);
    ready_a = 1'b1;
    #1;
    check("stall_accept_ready", 32'(rdy_a), 32'b0100);
    step();
    valid_a = 4'b0000; ready_a = 1'b0;
    #1;
    check("ptr_after_2", 32'(gid_a), 32'd3);
    valid_a = 4'b0010;
    #1;
    check("next_grant_1", 32'(gid_a), 32'd1);
    check("next_valid", 32'(ov_a), 32'd1);

    // locked requester drops valid while stalled
    step();
    valid_a = 4'b0100;
    #1;
    check("drop_valid", 32'(ov_a), 32'd0);
    check("drop_grant", 32'(gid_a), 32'd1);
    check("drop_busy", 32'(busy_a), 32'd1);
    step();
    ready_a = 1'b1;
    #1;
    check("drop_ready", 32'(rdy_a), 32'd0);
    check("drop_onehot", 32'(goh_a), 32'b0010);
    step();
    valid_a = 4'b0110;
    #1;
    check("reassert_ready", 32'(rdy_a), 32'b0010);
    step();
    valid_a = 4'b0100;
    #1;
    check("after_drop_grant", 32'(gid_a), 32'd2);
    check("after_drop_busy", 32'(busy_a), 32'd0);
    valid_a = 4'b0000; ready_a = 1'b0;

    // burst lock: req 0 sends 4 beats against a competing req 3
    valid_b = 4'b1001;
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      ready_b = c[0];
      last_b = {1'b1, 2'b00, (beat == 3)};
      data_b[31:0] = 32'hB000_0000 + 32'(beat);
      #1;
      check("burst_grant", 32'(gid_b), 32'd0);
      check("burst_data", od_b, 32'hB000_0000 + 32'(beat));
      check("burst_last", 32'(ol_b), (beat == 3) ? 32'd1 : 32'd0);
      if (c == 2) check("burst_busy", 32'(busy_b), 32'd1);
      step();
      if (ready_b) beat++;
    end
    ready_b = 1'b0;
    valid_b = 4'b1000;
    #1;
    check("burst_then_3", 32'(gid_b), 32'd3);
    valid_b = 4'b0000;
    #1;
    check("burst_ptr", 32'(gid_b), 32'd1);

    // async reset in the middle of a burst from req 3
    valid_b = 4'b1001; last_b = 4'b0001; ready_b = 1'b1;
    #1;
    check("rb_grant_3", 32'(gid_b), 32'd3);
    step();
    #1;
    check("rb_busy", 32'(busy_b), 32'd1);
    check("rb_beat2_grant", 32'(gid_b), 32'd3);
    rst_n_b = 1'b0;
    #1;
    check("rb_valid", 32'(ov_b), 32'd0);
    check("rb_ready", 32'(rdy_b), 32'd0);
    check("rb_onehot", 32'(goh_b), 32'd0);
    check("rb_busy0", 32'(busy_b), 32'd0);
    check("rb_grant0", 32'(gid_b), 32'd0);
    check("rb_last", 32'(ol_b), 32'd0);
    step();
    rst_n_b = 1'b1;
    #1;
    check("rb_after_grant", 32'(gid_b), 32'd0);
    check("rb_after_busy", 32'(busy_b), 32'd0);
    check("rb_after_ready", 32'(rdy_b), 32'b0001);
    valid_b = 4'b0000; ready_b = 1'b0;

    // N=3 rotation wraps 2 -> 0
    valid_c = 3'b111; ready_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("n3_grant", 32'(gid_c), 32'(i % 3));
      check("n3_data", od_c, 32'hCCCC_0000 + 32'(i % 3));
      step();
    end
    valid_c = 3'b000;
    #1;
    check("n3_ptr_wrap", 32'(gid_c), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter_lock.md
Name: axi_rr_arbiter_lock

Overview:
- N-to-1 round-robin arbiter for one AXI channel (AR, AW, W or B/R return) inside the interconnect arbitration tree.
- Selects one requester, muxes its payload onto the output, and holds that grant while the beat is stalled, so AXI valid/payload stability holds.
- Optionally holds the grant across a whole burst until LAST.
- Rotating priority pointer guarantees fairness: no requester waits more than N-1 accepted transactions.

Parameters:
- N_REQ, 4, number of requesters (>=2, need not be a power of 2)
- DATA_W, 32, payload width per requester
- ID_W, $clog2(N_REQ), width of grant index
- LOCK_LAST, 0, 1 = keep grant until beat with last=1 is accepted (W/R channels); 0 = release after every accepted beat

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  N_REQ  per-requester valid
- req_last_i  in  N_REQ  per-requester last flag (ignored when LOCK_LAST=0)
- req_data_i  in  N_REQ*DATA_W  packed payloads, requester k at [k*DATA_W +: DATA_W]
- req_ready_o  out  N_REQ  per-requester ready
- out_valid_o  out  1  muxed valid
- out_last_o  out  1  muxed last
- out_data_o  out  DATA_W  muxed payload
- out_ready_i  in  1  downstream ready
- grant_id_o  out  ID_W  index of current winner (for ID/route tagging)
- grant_onehot_o  out  N_REQ  one-hot winner, zero when no grant
- busy_o  out  1  1 while in LOCKED or BURST

Behaviour:
- State register: IDLE, LOCKED, BURST. rr_ptr register, ID_W bits. Both reset to IDLE / 0.
- Winner selection:
  - In IDLE, combinational. Winner = first k with req_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - In LOCKED/BURST, winner = registered lock_id, with no re-arbitration.
- Zero latency: in IDLE with any valid, out_valid_o=1 in the same cycle. out_* follow the winner.
- req_ready_o[k] = out_ready_i & (k == winner) & out_valid_o. All other ready bits are 0. No combinational path from out_ready_i to selection.
- Handshake (hs) = out_valid_o & out_ready_i.
- Transitions:
  - IDLE -> LOCKED: valid present, no hs. Register lock_id = winner.
  - IDLE/LOCKED -> BURST: hs, LOCK_LAST=1, last=0.
  - LOCKED -> IDLE: hs, and LOCK_LAST=0 or last=1.
  - BURST -> IDLE: hs with last=1.
  - IDLE stays IDLE: hs completing the transaction in the same cycle.
  - BURST with a stalled beat stays BURST.
- Pointer update: only when a transaction completes (hs, and LOCK_LAST=0 or last=1). rr_ptr <= winner+1, wrapping N_REQ-1 -> 0 explicitly (correct for non-power-of-2 N). No update on non-last beats or on stalls.
- Locked requester deasserts valid (protocol violation): grant is kept. out_valid_o follows the locked requester's valid. Other requesters stay blocked. No pointer change.
- No valid in IDLE:
  - out_valid_o=0, grant_onehot_o=0.
  - grant_id_o = rr_ptr.
  - out_data_o/out_last_o driven from requester rr_ptr; don't-care.
- Reset asserted mid-burst: immediate return to IDLE with rr_ptr=0. All outputs go to 0, except out_data_o, which shows requester 0 (don't-care).
- Reset values: out_valid_o=0, req_ready_o=0, grant_onehot_o=0, busy_o=0, grant_id_o=0.
- Outputs are combinational from state plus inputs. Only state, lock_id and rr_ptr are registered.

Decomposition:
- Shared package axi_arb_pkg: typedef arb_state_e {IDLE, LOCKED, BURST}; function rr_next(idx, n) for modulo increment.
- Sub-module axi_rr_prio_sel (combinational): rotating-priority first-one finder. Inputs req vector and rr_ptr; outputs winner id and found flag. Also reusable by R/B response arbiters.

Test Plan:
- N=4, reset, all valid=1, out_ready=1 held 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; one hs per cycle.
- Only req 2 valid, out_ready=0 for 3 cycles, then req 1 also asserts, then ready=1 -> grant stays 2, payload stable, busy_o=1. Accept 2; next cycle grant 1; rr_ptr becomes 3 after the accept of 2.
- LOCK_LAST=1, req 0 sends 4-beat burst (last on beat 4), req 3 valid throughout, ready toggling -> all 4 beats from 0 before any beat from 3; rr_ptr=1 after beat 4.
- N=3 (non-power-of-2), all valid, ready=1 -> grants 0,1,2,0,1,2; rr_ptr never equals 3.
- rst_n pulsed low during BURST beat 2 -> outputs 0 asynchronously; after release, IDLE, rr_ptr=0, req 0 wins if valid.
- Locked req 1 drops valid while stalled, req 2 valid -> out_valid_o=0, no grant to 2 until req 1 reasserts and completes.
